scan_master_seq: RTL and testbench
==================================

Name: scan_master_seq

Overview:
Sequencer that converts parallel host scan commands into the serial scan protocol used by the scan subchain demultiplexer. Per command it:
- drives a 12-bit subchain address;
- issues the one-cycle parallel-capture slot;
- shifts a variable-length data field, serialising write data out on scan_in and collecting read data from scan_out;
- closes with a scan_en-low gap.

It sits between the chip-level configuration host and the subchain address decoder, and is the only driver of scan_en, scan_in and take_scanout_data.

Parameters:
- ADDR_W, 12, subchain address width; shifted MSB first.
- DATA_W, 140, maximum data field length in bits.
- LEN_W, 8, width of cmd_len.
- GAP_CYCLES, 2, cycles of scan_en low after each command; legal range 1..15.

Ports:
- scan_clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid&&cmd_ready.
- cmd_read  in  1  1 = capture before shifting (read-modify-write); 0 = write only.
- cmd_addr  in  ADDR_W  target subchain address.
- cmd_len  in  LEN_W  number of data bits to shift.
- cmd_wdata  in  DATA_W  write data, right-justified.
- abort  in  1  terminates the current command.
- scan_en  out  1  scan enable to the subchain.
- scan_in  out  1  serial data to the subchain.
- take_scanout_data  out  1  parallel-capture request.
- scan_out  in  1  serial return from the selected subchain.
- rsp_valid  out  1  response available; held until rsp_ready.
- rsp_ready  in  1  response accept.
- rsp_rdata  out  DATA_W  captured bits, right-justified.
- rsp_aborted  out  1  the response belongs to an aborted command.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered. Reset values:
  - scan_en, scan_in, take_scanout_data, rsp_valid, rsp_aborted, busy = 0;
  - cmd_ready = 1; rsp_rdata = 0; FSM = IDLE.
- Reset asserted mid-command forces scan_en low asynchronously; the command is dropped and no response is produced.
- Length normalisation at accept: eff_len = DATA_W if cmd_len==0 or cmd_len>DATA_W, else cmd_len.
- At accept, the command is latched into internal registers. rsp_rdata is cleared at accept.
- FSM states:
  - IDLE: cmd_ready=1, scan_en=0. On accept go to ADDR.
  - ADDR: exactly ADDR_W cycles, scan_en=1.
    - scan_in = cmd_addr[ADDR_W-1] on the first cycle, down to cmd_addr[0] on the last.
    - Bit counter runs ADDR_W-1 down to 0; at 0 go to CAP.
  - CAP: 1 cycle, scan_en=1, scan_in=0, take_scanout_data=cmd_read. The next state is DATA.
  - DATA: eff_len cycles, scan_en=1.
    - scan_in = wdata[eff_len-1] first, down to wdata[0].
    - Each cycle, scan_out is sampled at the closing posedge and shifted in: rdata <= {rdata[DATA_W-2:0], scan_out}.
    - On the last bit go to GAP.
  - GAP: GAP_CYCLES cycles, scan_en=0, scan_in=0. Then go to RESP.
  - RESP: rsp_valid=1, with rsp_rdata and rsp_aborted stable. On rsp_ready go to IDLE.
    - rsp_valid drops on the same edge that the handshake occurs.
    - cmd_ready rises on that edge, so back-to-back commands are separated by at least 1 IDLE cycle.
- Latency: scan_en is first high in the cycle after accept. Total cycles from accept to rsp_valid = ADDR_W + 1 + eff_len + GAP_CYCLES.
- abort:
  - Sampled in ADDR, CAP or DATA: the next state is GAP, scan_en falls on the next edge, and rsp_aborted=1.
  - Ignored in IDLE, GAP and RESP.
  - If abort arrives on the last DATA cycle, abort wins: rsp_aborted=1.
- cmd_valid outside IDLE is ignored and command inputs are not sampled. cmd_* may change freely once the command is accepted.
- take_scanout_data is asserted only in CAP and is never high for more than one cycle per command.

Test Plan:
- Write, cmd_addr=0x005, cmd_len=8, cmd_wdata=0xA5, cmd_read=0:
  - scan_en high for exactly 21 cycles;
  - scan_in over the 12 ADDR cycles = 000000000101;
  - take_scanout_data never 1;
  - DATA bits = 10100101;
  - rsp_valid 2 cycles after scan_en falls;
  - rsp_aborted=0.
- Read, cmd_addr=0x00A, cmd_len=0, cmd_read=1, scan_out driven by a 140-bit model:
  - take_scanout_data=1 for exactly 1 cycle, immediately after the 12th address bit;
  - 140 DATA cycles;
  - rsp_rdata equals the model's pattern.
- cmd_len=200 -> treated as 140; scan_en high for 153 cycles.
- abort pulsed on the 3rd DATA cycle of a len=16 command:
  - scan_en low on the next edge;
  - GAP then RESP with rsp_aborted=1;
  - rsp_rdata holds 3 bits.
- rsp_ready held low for 10 cycles -> rsp_valid/rsp_rdata stable and cmd_ready=0 throughout; cmd_valid asserted during the wait is not accepted.
- reset asserted mid-ADDR -> scan_en=0 immediately with no clock edge; after release, cmd_ready=1 and a new command completes normally.

Source files
------------

// File: rtl/scan_master_seq.sv
// scan_master_seq: turns parallel host scan commands into the serial address/capture/data/gap scan protocol.
module scan_master_seq #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 140,
  parameter int LEN_W      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic              scan_clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_read,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              abort,
  output logic              scan_en,
  output logic              scan_in,
  output logic              take_scanout_data,
  input  logic              scan_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_aborted,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, ADDR, CAP, DATA, GAP, RESP} state_t;
  localparam logic [LEN_W-1:0] DLEN  = LEN_W'(DATA_W);
  localparam logic [LEN_W-1:0] GAP_N = LEN_W'(GAP_CYCLES - 1);
  localparam logic [LEN_W-1:0] ADR_N = LEN_W'(ADDR_W - 1);
  state_t state, state_n;
  logic [LEN_W-1:0] cnt, cnt_n, eff_len, len_r;
  logic [ADDR_W-1:0] addr_sh;
  logic [DATA_W-1:0] wd_sh;
  logic read_r, accept, abort_ok;
  assign accept   = state == IDLE && cmd_valid;
  assign abort_ok = abort && state inside {ADDR, CAP, DATA};
  assign eff_len  = (cmd_len == '0 || cmd_len > DLEN) ? DLEN : cmd_len;
  always_ff @(posedge scan_clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: if (cmd_valid) begin
        state_n = ADDR;
        cnt_n   = ADR_N;
      end
      ADDR: if (cnt == '0) state_n = CAP; else cnt_n = cnt - 1'b1;
      CAP: begin
        state_n = DATA;
        cnt_n   = len_r - 1'b1;
      end
      DATA: if (cnt == '0) begin
        state_n = GAP;
        cnt_n   = GAP_N;
      end else cnt_n = cnt - 1'b1;
      GAP:  if (cnt == '0) state_n = RESP; else cnt_n = cnt - 1'b1;
      RESP: if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort_ok) begin
      state_n = GAP;
      cnt_n   = GAP_N;
    end
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge scan_clk or posedge reset)
    if (reset) begin
      cmd_ready         <= 1'b1;
      busy              <= 1'b0;
      rsp_valid         <= 1'b0;
      scan_en           <= 1'b0;
      scan_in           <= 1'b0;
      take_scanout_data <= 1'b0;
      rsp_rdata         <= '0;
      rsp_aborted       <= 1'b0;
      addr_sh           <= '0;
      wd_sh             <= '0;
      len_r             <= '0;
      read_r            <= 1'b0;
    end else begin
      cmd_ready         <= state_n == IDLE;
      busy              <= state_n != IDLE;
      rsp_valid         <= state_n == RESP;
      scan_en           <= state_n inside {ADDR, CAP, DATA};
      take_scanout_data <= state_n == CAP && read_r;
      scan_in           <= accept ? cmd_addr[ADDR_W-1] :
                           state_n == ADDR ? addr_sh[ADDR_W-1] :
                           state_n == DATA ? wd_sh[DATA_W-1] : 1'b0;
      if (accept) begin
        addr_sh     <= cmd_addr << 1;
        wd_sh       <= cmd_wdata << (DLEN - eff_len);
        len_r       <= eff_len;
        read_r      <= cmd_read;
        rsp_rdata   <= '0;
        rsp_aborted <= 1'b0;
      end else if (state_n == ADDR) addr_sh <= addr_sh << 1;
      if (state_n == DATA) wd_sh <= wd_sh << 1;
      if (state == DATA) rsp_rdata <= {rsp_rdata[DATA_W-2:0], scan_out};
      if (abort_ok) rsp_aborted <= 1'b1;
    end
endmodule

// File: tb/tb_scan_master_seq.sv
// tb_scan_master_seq: directed checks of the scan command sequencer.
module tb_scan_master_seq;
  localparam int DW = 140;
  logic scan_clk = 1'b0;
  logic reset, cmd_valid, cmd_ready, cmd_read, abort, scan_en, scan_in;
  logic take_scanout_data, scan_out, rsp_valid, rsp_ready, rsp_aborted, busy;
  logic [11:0] cmd_addr;
  logic [7:0] cmd_len;
  logic [DW-1:0] cmd_wdata, rsp_rdata;
  int checks = 0, failures = 0;
  int en_cnt, take_cnt, take_k, rsp_k, low_k, bad;
  logic [11:0] addr_bits;
  logic [DW-1:0] data_bits, rv;
  logic [DW-1:0] pat2, wd3;
  scan_master_seq dut (
    .scan_clk(scan_clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_read(cmd_read), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .abort(abort), .scan_en(scan_en), .scan_in(scan_in), .take_scanout_data(take_scanout_data),
    .scan_out(scan_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_aborted(rsp_aborted), .busy(busy)
  );
  always #5 scan_clk = ~scan_clk;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge scan_clk);
    #1;
  endtask
  task automatic ack;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask
  // Issues one command and follows it cycle by cycle until rsp_valid; k counts cycles after accept.
  task automatic run_cmd(input logic rd, input logic [11:0] a, input logic [7:0] l,
                         input logic [DW-1:0] wd, input int eff, input logic [DW-1:0] pat,
                         input int abort_at);
    en_cnt = 0; take_cnt = 0; take_k = -1; rsp_k = -1; low_k = -1;
    addr_bits = '0; data_bits = '0;
    cmd_read = rd; cmd_addr = a; cmd_len = l; cmd_wdata = wd; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0; cmd_addr = 12'hFFF; cmd_wdata = '1; cmd_len = 8'd3; cmd_read = ~rd;
    for (int k = 0; k < 400; k++) begin
      if (rsp_valid) begin
        rsp_k = k;
        break;
      end
      if (scan_en) en_cnt++;
      else if (low_k < 0 && en_cnt > 0) low_k = k;
      if (take_scanout_data) begin
        take_cnt++;
        take_k = k;
      end
      if (k < 12) addr_bits = {addr_bits[10:0], scan_in};
      if (k >= 13 && k < 13 + eff && scan_en) data_bits = {data_bits[DW-2:0], scan_in};
      scan_out = (k >= 13 && k < 13 + eff) ? pat[eff-1-(k-13)] : 1'b0;
      abort = abort_at > 0 && k == 12 + abort_at;
      tick;
    end
    abort = 1'b0;
    scan_out = 1'b0;
  endtask
  initial begin
    pat2 = {12'h9C5, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
    wd3  = {12'h5A3, 64'hDEAD_BEEF_0BAD_F00D, 64'h1357_9BDF_2468_ACE0};
    reset = 1'b1; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_wdata = '0; abort = 1'b0; scan_out = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge scan_clk);
    #1;
    chk("rst_cmd_ready", DW'(cmd_ready), DW'(1));
    chk("rst_scan_en", DW'(scan_en), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_rsp_valid", DW'(rsp_valid), DW'(0));
    chk("rst_rdata", rsp_rdata, '0);
    reset = 1'b0;
    tick;
    run_cmd(1'b0, 12'h005, 8'd8, DW'(8'hA5), 8, DW'(8'h3C), 0);
    chk("wr_en_cycles", DW'(en_cnt), DW'(21));
    chk("wr_addr_bits", DW'(addr_bits), DW'(12'h005));
    chk("wr_take_cnt", DW'(take_cnt), DW'(0));
    chk("wr_data_bits", data_bits, DW'(8'hA5));
    chk("wr_rsp_k", DW'(rsp_k), DW'(23));
    chk("wr_gap", DW'(rsp_k - low_k), DW'(2));
    chk("wr_aborted", DW'(rsp_aborted), DW'(0));
    chk("wr_rdata", rsp_rdata, DW'(8'h3C));
    chk("wr_ready_in_resp", DW'(cmd_ready), DW'(0));
    ack;
    chk("wr_ack_valid", DW'(rsp_valid), DW'(0));
    chk("wr_ack_ready", DW'(cmd_ready), DW'(1));
    run_cmd(1'b1, 12'h00A, 8'd0, '0, 140, pat2, 0);
    chk("rd_take_cnt", DW'(take_cnt), DW'(1));
    chk("rd_take_k", DW'(take_k), DW'(12));
    chk("rd_en_cycles", DW'(en_cnt), DW'(153));
    chk("rd_addr_bits", DW'(addr_bits), DW'(12'h00A));
    chk("rd_rsp_k", DW'(rsp_k), DW'(155));
    chk("rd_rdata", rsp_rdata, pat2);
    ack;
    run_cmd(1'b0, 12'h7E1, 8'd200, wd3, 140, '0, 0);
    chk("long_en_cycles", DW'(en_cnt), DW'(153));
    chk("long_data_bits", data_bits, wd3);
    chk("long_rsp_k", DW'(rsp_k), DW'(155));
    ack;
    run_cmd(1'b0, 12'h0F0, 8'd16, DW'(16'h1234), 16, DW'(16'hB6C9), 3);
    chk("abort_en_cycles", DW'(en_cnt), DW'(16));
    chk("abort_en_fall_k", DW'(low_k), DW'(16));
    chk("abort_rsp_k", DW'(rsp_k), DW'(18));
    chk("abort_flag", DW'(rsp_aborted), DW'(1));
    chk("abort_rdata", rsp_rdata, DW'(3'b101));
    ack;
    run_cmd(1'b0, 12'h123, 8'd4, DW'(4'h9), 4, DW'(4'h6), 0);
    chk("hold_rsp_k", DW'(rsp_k), DW'(19));
    chk("hold_rdata", rsp_rdata, DW'(4'h6));
    rv = rsp_rdata;
    bad = 0;
    cmd_valid = 1'b1;
    cmd_addr = 12'h555;
    for (int i = 0; i < 10; i++) begin
      if (!rsp_valid || rsp_rdata !== rv || cmd_ready || !busy || scan_en) bad++;
      tick;
    end
    chk("hold_stable", DW'(bad), DW'(0));
    cmd_valid = 1'b0;
    ack;
    chk("hold_ack_valid", DW'(rsp_valid), DW'(0));
    repeat (3) tick;
    chk("hold_no_accept_en", DW'(scan_en), DW'(0));
    chk("hold_no_accept_busy", DW'(busy), DW'(0));
    cmd_read = 1'b0; cmd_addr = 12'hFFF; cmd_len = 8'd8; cmd_wdata = '0; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    repeat (2) tick;
    chk("rst_mid_pre_en", DW'(scan_en), DW'(1));
    #3 reset = 1'b1;
    #1;
    chk("rst_mid_en", DW'(scan_en), DW'(0));
    chk("rst_mid_ready", DW'(cmd_ready), DW'(1));
    chk("rst_mid_busy", DW'(busy), DW'(0));
    @(posedge scan_clk);
    #2 reset = 1'b0;
    tick;
    chk("rst_rel_ready", DW'(cmd_ready), DW'(1));
    run_cmd(1'b0, 12'h3C3, 8'd5, DW'(5'h16), 5, DW'(5'h0D), 0);
    chk("post_addr_bits", DW'(addr_bits), DW'(12'h3C3));
    chk("post_data_bits", data_bits, DW'(5'h16));
    chk("post_rdata", rsp_rdata, DW'(5'h0D));
    chk("post_rsp_k", DW'(rsp_k), DW'(20));
    chk("post_aborted", DW'(rsp_aborted), DW'(0));
    ack;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
